// File: rtl/sdram_word_mem_model.sv
// Behavioural 32-bit word SDRAM model with request/busy handshake.
// Optional refresh handling enabled by defining SDRAM_REFRESH_EN.
module sdram_word_mem_model #(
    parameter int MEM_SIZE = 65536,
    parameter int RD_LAT   = 4,
    parameter int WR_LAT   = 4,
    parameter int REF_LAT  = 8
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] w_addr,
    input  logic        w_le,
    input  logic        w_we,
    input  logic [31:0] w_wdata,
    input  logic [3:0]  w_mask,
    input  logic        w_refresh,
    input  logic [31:0] w_mtime,
    output logic [31:0] w_odata,
    output logic        w_stall
);

    localparam int AW = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, READ, WRITE, REFRESH} state_t;

    state_t        state_q;
    logic [31:0]   cnt_q;
    logic [AW-3:0] widx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mask_q;
    logic [31:0]   odata_q;
    logic          stall_q;

    logic [7:0]    mem [0:MEM_SIZE-1];

    logic          ref_req;
    logic          last;
    logic          mem_we;
    logic [31:0]   rdata;
    logic          unused;

`ifdef SDRAM_REFRESH_EN
    assign ref_req = w_refresh;
`else
    assign ref_req = 1'b0;
`endif

    assign unused  = ^{w_mtime, w_addr[31:AW], w_addr[1:0], w_refresh};

    assign last    = (cnt_q == 32'd1);
    // Reset in the final busy cycle still suppresses the commit.
    assign mem_we  = !rst && (state_q == WRITE) && last;

    assign rdata   = {mem[{widx_q, 2'd3}], mem[{widx_q, 2'd2}],
                      mem[{widx_q, 2'd1}], mem[{widx_q, 2'd0}]};

    assign w_odata = odata_q;
    assign w_stall = stall_q;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem[{widx_q, i[1:0]}] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            stall_q <= 1'b0;
            odata_q <= 32'd0;
            widx_q  <= '0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    widx_q  <= w_addr[AW-1:2];
                    wdata_q <= w_wdata;
                    mask_q  <= w_mask;
                    if (w_le) begin
                        state_q <= READ;
                        cnt_q   <= 32'(RD_LAT);
                        stall_q <= 1'b1;
                    end else if (w_we) begin
                        state_q <= WRITE;
                        cnt_q   <= 32'(WR_LAT);
                        stall_q <= 1'b1;
                    end else if (ref_req) begin
                        state_q <= REFRESH;
                        cnt_q   <= 32'(REF_LAT);
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - 32'd1;
                    if (last) begin
                        state_q <= IDLE;
                        stall_q <= 1'b0;
                        if (state_q == READ) begin
                            odata_q <= rdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_word_mem_model.sv
// Scoreboard-driven bench for sdram_word_mem_model.
// Expected read words are queued at issue and checked when busy drops.
module tb_sdram_word_mem_model;

    localparam int MEM_SIZE = 65536;
    localparam int RD_LAT   = 4;
    localparam int WR_LAT   = 4;
`ifdef SDRAM_REFRESH_EN
    localparam int EXP_REF  = 8;
`else
    localparam int EXP_REF  = 0;
`endif

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] w_addr = '0;
    logic        w_le = 1'b0;
    logic        w_we = 1'b0;
    logic [31:0] w_wdata = '0;
    logic [3:0]  w_mask = '0;
    logic        w_refresh = 1'b0;
    logic [31:0] w_mtime = '0;
    logic [31:0] w_odata;
    logic        w_stall;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    sdram_word_mem_model #(
        .MEM_SIZE(MEM_SIZE),
        .RD_LAT  (RD_LAT),
        .WR_LAT  (WR_LAT),
        .REF_LAT (8)
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .w_addr   (w_addr),
        .w_le     (w_le),
        .w_we     (w_we),
        .w_wdata  (w_wdata),
        .w_mask   (w_mask),
        .w_refresh(w_refresh),
        .w_mtime  (w_mtime),
        .w_odata  (w_odata),
        .w_stall  (w_stall)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) w_mtime <= w_mtime + 32'd1;

    task automatic issue(input logic le, input logic we, input logic rf,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int busy);
        @(negedge CLK);
        w_le = le; w_we = we; w_refresh = rf;
        w_addr = a; w_wdata = d; w_mask = m;
        @(negedge CLK);
        w_le = 1'b0; w_we = 1'b0; w_refresh = 1'b0;
        busy = 0;
        while (w_stall === 1'b1 && busy < 100) begin
            busy++;
            @(negedge CLK);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (sb.size() == 0) return 32'hxxxx_xxxx;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if (w_stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall: got %b want 0", w_stall);
        end
        total++;
        if (w_odata !== 32'd0) begin
            bad++; $display("FAIL reset_odata: got %h want 0", w_odata);
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        int b;
        logic [31:0] e;
        issue(0, 1, 0, 32'h100, 32'h11223344, 4'hF, b);
        total++;
        if (b !== WR_LAT) begin
            bad++; $display("FAIL word_wr_busy: got %0d want %0d", b, WR_LAT);
        end
        sb.push_back(32'h11223344);
        issue(1, 0, 0, 32'h100, 32'h0, 4'h0, b);
        total++;
        if (b !== RD_LAT) begin
            bad++; $display("FAIL word_rd_busy: got %0d want %0d", b, RD_LAT);
        end
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL word_rd_data: got %h want %h", w_odata, e);
        end
    endtask

    task automatic test_mask();
        int b;
        logic [31:0] e;
        issue(0, 1, 0, 32'h20, 32'hAABBCCDD, 4'hF, b);
        issue(0, 1, 0, 32'h20, 32'h00EE0000, 4'b0100, b);
        sb.push_back(32'hAAEECCDD);
        issue(1, 0, 0, 32'h20, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL mask_lane2: got %h want %h", w_odata, e);
        end
        issue(0, 1, 0, 32'h20, 32'h12345678, 4'h0, b);
        total++;
        if (b !== WR_LAT) begin
            bad++; $display("FAIL mask0_busy: got %0d want %0d", b, WR_LAT);
        end
        sb.push_back(32'hAAEECCDD);
        issue(1, 0, 0, 32'h20, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL mask0_data: got %h want %h", w_odata, e);
        end
    endtask

    task automatic test_priority();
        int b;
        int n;
        logic [31:0] e;
        logic [9:0] pat;
        issue(0, 1, 0, 32'h40, 32'hCAFEF00D, 4'hF, b);
        sb.push_back(32'hCAFEF00D);
        issue(1, 1, 0, 32'h40, 32'h0, 4'hF, b);
        total++;
        if (b !== RD_LAT) begin
            bad++; $display("FAIL prio_busy: got %0d want %0d", b, RD_LAT);
        end
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL prio_read: got %h want %h", w_odata, e);
        end
        // write pulse while busy must be dropped
        @(negedge CLK);
        w_le = 1'b1; w_addr = 32'h40;
        @(negedge CLK);
        w_le = 1'b0; w_we = 1'b1; w_wdata = 32'h0; w_mask = 4'hF;
        @(negedge CLK);
        w_we = 1'b0;
        n = 0;
        while (w_stall === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        sb.push_back(32'hCAFEF00D);
        issue(1, 0, 0, 32'h40, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL busy_ignore: got %h want %h", w_odata, e);
        end
        // held read request re-triggers after busy falls
        sb.push_back(32'hCAFEF00D);
        sb.push_back(32'hCAFEF00D);
        pat = '0;
        @(negedge CLK);
        w_le = 1'b1; w_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            pat = {pat[8:0], w_stall};
            if (i == 4 || i == 9) begin
                e = pop_exp();
                total++;
                if (w_odata !== e) begin
                    bad++; $display("FAIL hold_read%0d: got %h want %h", i, w_odata, e);
                end
            end
        end
        w_le = 1'b0;
        total++;
        if (pat !== 10'b1111011110) begin
            bad++; $display("FAIL hold_pattern: got %b want 1111011110", pat);
        end
    endtask

    task automatic test_refresh();
        int b;
        logic [31:0] e;
        issue(0, 0, 1, 32'h0, 32'h0, 4'h0, b);
        total++;
        if (b !== EXP_REF) begin
            bad++; $display("FAIL refresh_busy: got %0d want %0d", b, EXP_REF);
        end
        total++;
        if (w_odata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL refresh_odata: got %h want cafef00d", w_odata);
        end
        sb.push_back(32'hAAEECCDD);
        issue(1, 0, 0, 32'h20, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL refresh_mem: got %h want %h", w_odata, e);
        end
    endtask

    task automatic test_reset_mid_write();
        int b;
        logic [31:0] e;
        issue(0, 1, 0, 32'h80, 32'h0, 4'hF, b);
        @(negedge CLK);
        w_we = 1'b1; w_addr = 32'h80; w_wdata = 32'hDEADBEEF; w_mask = 4'hF;
        @(negedge CLK);
        w_we = 1'b0;
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        total++;
        if (w_stall !== 1'b0) begin
            bad++; $display("FAIL midrst_stall: got %b want 0", w_stall);
        end
        total++;
        if (w_odata !== 32'd0) begin
            bad++; $display("FAIL midrst_odata: got %h want 0", w_odata);
        end
        rst = 1'b0;
        sb.push_back(32'h0);
        issue(1, 0, 0, 32'h80, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL midrst_mem: got %h want %h", w_odata, e);
        end
    endtask

    task automatic test_wrap();
        int b;
        logic [31:0] e;
        issue(0, 1, 0, MEM_SIZE + 32'h8, 32'h12345678, 4'hF, b);
        sb.push_back(32'h12345678);
        issue(1, 0, 0, 32'h8, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL wrap_8: got %h want %h", w_odata, e);
        end
        sb.push_back(32'h12345678);
        issue(0, 1, 0, 32'h0, 32'h0, 4'hF, b);
        issue(1, 0, 0, 32'hB, 32'h0, 4'h0, b);
        e = pop_exp();
        total++;
        if (w_odata !== e) begin
            bad++; $display("FAIL wrap_B: got %h want %h", w_odata, e);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_mask();
        test_priority();
        test_refresh();
        test_reset_mid_write();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_word_mem_model.md
Name: sdram_word_mem_model

Overview:
- Cycle-approximate behavioural model of a 32-bit-word SDRAM behind a request/busy handshake.
- Used in simulation in place of the real SDRAM controller beneath the byte-granular DRAM front-end.
- Accepts word-aligned reads, byte-masked writes and refresh requests; each is reported via a multi-cycle busy pulse.
- Storage is a byte array preloadable hierarchically by the bench.

Parameters:
- MEM_SIZE, 65536, storage size in bytes; must be a power of two and at least 4.
- RD_LAT, 4, busy cycles for a read (min 1).
- WR_LAT, 4, busy cycles for a write (min 1).
- REF_LAT, 8, busy cycles for a refresh (min 1).

Ports:
- CLK  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- w_addr  in  32  byte address; bits [1:0] ignored, word index = w_addr[log2(MEM_SIZE)-1:2].
- w_le  in  1  read request (level).
- w_we  in  1  write request (level).
- w_wdata  in  32  write data, little-endian (byte0 = bits 7:0).
- w_mask  in  4  byte enables; 1 = write that byte lane.
- w_refresh  in  1  refresh request (level).
- w_mtime  in  32  timer value; debug only, no functional effect.
- w_odata  out  32  read data.
- w_stall  out  1  busy.

Behaviour:
- Storage: reg [7:0] mem[0:MEM_SIZE-1]; word k occupies bytes 4k..4k+3, little-endian. Contents not affected by reset and not initialised by RTL.
- FSM states: IDLE, READ, WRITE, REFRESH; 32-bit down-counter cnt.
- Reset: state IDLE, w_stall=0, w_odata=0, cnt=0. Reset during an operation aborts it: a pending write is not committed and w_odata keeps 0.
- IDLE acceptance, sampled at a rising edge with w_stall=0:
  - Priority is w_le > w_we > w_refresh.
  - Latch address, wdata and mask.
  - Load cnt with the latency for that operation; set w_stall=1 from the next cycle.
  - Enter the matching state.
- Busy states: decrement cnt each cycle. When cnt reaches 1 (last busy cycle), at that edge:
  - READ: w_odata <= word at latched address.
  - WRITE: write each enabled byte lane of the latched wdata.
  - REFRESH: no storage effect.
  - Then w_stall <= 0 and state IDLE.
- Timing: request sampled at edge N → w_stall high for exactly LAT cycles starting N+1 → low from edge N+1+LAT. For reads, w_odata is valid in that same cycle.
- w_odata holds its value until the next read completes; writes and refreshes never change it.
- Requests while w_stall=1 are ignored and not queued.
- The master must drop the request once it sees w_stall=1. A request still high in the first idle cycle is accepted as a new operation.
- w_mask=0 write: full busy pulse, no storage change.
- Address wrap: addresses beyond MEM_SIZE alias modulo MEM_SIZE. Bits [1:0] are always dropped, so no misaligned access exists at this level.

Optional Feature:
- SDRAM_REFRESH_EN defined: w_refresh is honoured as above (REF_LAT busy cycles, lowest priority).
- Undefined: w_refresh is ignored entirely; only reads and writes raise w_stall. The port remains present.

Test Plan:
- Word write/read: w_we addr 0x100, data 0x11223344, mask 1111. Then w_le addr 0x100 → w_stall high 4 cycles each; w_odata=0x11223344 when w_stall falls.
- Byte masks: preset 0xAABBCCDD at 0x20; write 0x00EE0000 mask 0100; read 0x20 → 0xAAEECCDD. A mask-0000 write leaves it unchanged.
- Busy ignore and priority:
  - Assert w_le and w_we together at 0x40 → read is performed.
  - A w_we pulse during busy has no effect.
  - Holding w_le through busy-fall triggers a second read.
- Refresh with SDRAM_REFRESH_EN: w_refresh pulse → w_stall high 8 cycles; w_odata and memory unchanged. Without the macro → w_stall stays 0.
- Reset mid-write: rst in the second busy cycle of a write of 0xDEADBEEF to 0x80 (old 0x0) → w_stall=0 and w_odata=0 next cycle; later read of 0x80 returns 0x0.
- Wrap and alignment: write 0x12345678 to MEM_SIZE+0x8; reads of 0x8 and 0xB both return 0x12345678.
